// File: rtl/sram_kn_tile_reader.sv
// sram_kn_tile_reader: sweeps k rows x N columns of a k/n SRAM port, credit-limited reads, FIFO-buffered tagged output stream.
module sram_kn_tile_reader #(
  parameter int KMAX = 1024,
  parameter int N = 8,
  parameter int DATA_W = 32,
  parameter int BYTE_W = DATA_W / 8,
  parameter int FIFO_D = 4,
  parameter int K_W = (KMAX <= 1) ? 1 : $clog2(KMAX),
  parameter int N_W = (N <= 1) ? 1 : $clog2(N)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [K_W-1:0]    cmd_k_base,
  input  logic [K_W:0]      cmd_k_len,
  output logic              busy,
  output logic              done,
  output logic              err_cmd,
  output logic              err_unexp,
  output logic              x_en,
  output logic              x_re,
  output logic              x_we,
  output logic [K_W-1:0]    x_k,
  output logic [N_W-1:0]    x_n,
  output logic [DATA_W-1:0] x_wdata,
  output logic [BYTE_W-1:0] x_wmask,
  input  logic [DATA_W-1:0] x_rdata,
  input  logic              x_rvalid,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic [K_W-1:0]    out_k,
  output logic [N_W-1:0]    out_n,
  output logic              out_last
);
  localparam int PW = (FIFO_D <= 2) ? 1 : $clog2(FIFO_D);
  localparam int CW = $clog2(FIFO_D + 1);
  typedef enum logic [1:0] {IDLE, ISSUE, DRAIN} state_t;
  state_t state;
  logic [K_W-1:0] k, k_last;
  logic [N_W-1:0] n;
  logic [CW-1:0] inflight, count;
  logic [PW-1:0] tq_wr, tq_rd, f_wr, f_rd;
  logic [K_W-1:0] tq_k [FIFO_D];
  logic [N_W-1:0] tq_n [FIFO_D];
  logic tq_l [FIFO_D];
  logic [DATA_W-1:0] f_d [FIFO_D];
  logic [K_W-1:0] f_k [FIFO_D];
  logic [N_W-1:0] f_n [FIFO_D];
  logic f_l [FIFO_D];
  logic done_r, issue, push, pop, last_addr;
  logic [K_W+1:0] k_end;
  function automatic logic [PW-1:0] nxt(input logic [PW-1:0] p);
    return (p == PW'(FIFO_D - 1)) ? '0 : p + 1'b1;
  endfunction
  assign k_end = {2'b0, cmd_k_base} + {1'b0, cmd_k_len};
  assign last_addr = (k == k_last) && (n == N_W'(N - 1));
  // credit covers reads still in flight, so the FIFO can never overflow
  assign issue = (state == ISSUE) && (({1'b0, count} + {1'b0, inflight}) < (CW+1)'(FIFO_D));
  assign push = x_rvalid && (inflight != '0);
  assign out_valid = count != '0;
  assign pop = out_valid && out_ready;
  assign out_data = out_valid ? f_d[f_rd] : '0;
  assign out_k = out_valid ? f_k[f_rd] : '0;
  assign out_n = out_valid ? f_n[f_rd] : '0;
  assign out_last = out_valid && f_l[f_rd];
  assign cmd_ready = state == IDLE;
  assign busy = state != IDLE;
  assign done = done_r || ((state == DRAIN) && pop && out_last);
  assign x_re = x_en;
  assign x_we = 1'b0;
  assign x_wdata = '0;
  assign x_wmask = '0;
  always_ff @(posedge clk) begin
    if (issue) begin
      tq_k[tq_wr] <= k;
      tq_n[tq_wr] <= n;
      tq_l[tq_wr] <= last_addr;
    end
    if (push) begin
      f_d[f_wr] <= x_rdata;
      f_k[f_wr] <= tq_k[tq_rd];
      f_n[f_wr] <= tq_n[tq_rd];
      f_l[f_wr] <= tq_l[tq_rd];
    end
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      k <= '0;
      n <= '0;
      k_last <= '0;
      inflight <= '0;
      count <= '0;
      tq_wr <= '0;
      tq_rd <= '0;
      f_wr <= '0;
      f_rd <= '0;
      done_r <= 1'b0;
      err_cmd <= 1'b0;
      err_unexp <= 1'b0;
      x_en <= 1'b0;
      x_k <= '0;
      x_n <= '0;
    end else begin
      done_r <= 1'b0;
      err_cmd <= 1'b0;
      x_en <= issue;
      if (x_rvalid && inflight == '0) err_unexp <= 1'b1;
      if (issue) begin
        x_k <= k;
        x_n <= n;
        tq_wr <= nxt(tq_wr);
        n <= (n == N_W'(N - 1)) ? '0 : n + 1'b1;
        if (n == N_W'(N - 1)) k <= k + 1'b1;
      end
      if (push) begin
        tq_rd <= nxt(tq_rd);
        f_wr <= nxt(f_wr);
      end
      if (pop) f_rd <= nxt(f_rd);
      inflight <= inflight + CW'(issue) - CW'(push);
      count <= count + CW'(push) - CW'(pop);
      case (state)
        IDLE: if (cmd_valid) begin
          if (cmd_k_len == '0) done_r <= 1'b1;
          else if (k_end > (K_W+2)'(KMAX)) begin
            done_r <= 1'b1;
            err_cmd <= 1'b1;
          end else begin
            k <= cmd_k_base;
            n <= '0;
            k_last <= K_W'(k_end - 1'b1);
            state <= ISSUE;
          end
        end
        ISSUE: if (issue && last_addr) state <= DRAIN;
        DRAIN: if (pop && out_last) state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_sram_kn_tile_reader.sv
// tb_sram_kn_tile_reader: directed scenarios against a 1-cycle-latency memory model returning {k,n}-coded words.
module tb_sram_kn_tile_reader;
  localparam int N = 8;
  localparam int FD = 4;
  logic clk = 0;
  logic rst = 1;
  logic cmd_valid = 0, cmd_ready;
  logic [9:0] cmd_k_base = '0;
  logic [10:0] cmd_k_len = '0;
  logic busy, done, err_cmd, err_unexp;
  logic x_en, x_re, x_we;
  logic [9:0] x_k;
  logic [2:0] x_n;
  logic [31:0] x_wdata, x_rdata;
  logic [3:0] x_wmask;
  logic x_rvalid;
  logic out_valid, out_ready = 0, out_last;
  logic [31:0] out_data;
  logic [9:0] out_k;
  logic [2:0] out_n;
  logic mrv, force_rv = 0;
  logic [31:0] mrd;
  int errors = 0, checks = 0;

  always #5 clk = ~clk;

  sram_kn_tile_reader dut (
    .clk(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_k_base(cmd_k_base), .cmd_k_len(cmd_k_len), .busy(busy), .done(done),
    .err_cmd(err_cmd), .err_unexp(err_unexp), .x_en(x_en), .x_re(x_re), .x_we(x_we),
    .x_k(x_k), .x_n(x_n), .x_wdata(x_wdata), .x_wmask(x_wmask), .x_rdata(x_rdata),
    .x_rvalid(x_rvalid), .out_valid(out_valid), .out_ready(out_ready),
    .out_data(out_data), .out_k(out_k), .out_n(out_n), .out_last(out_last)
  );

  function automatic logic [31:0] word(input logic [9:0] k, input logic [2:0] n);
    return {6'h2A, k, 13'd0, n};
  endfunction

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mrv <= 1'b0;
      mrd <= '0;
    end else begin
      mrv <= x_en && x_re;
      mrd <= word(x_k, x_n);
    end
  end
  assign x_rvalid = mrv | force_rv;
  assign x_rdata = mrd;

  task automatic run_cmd(input int base, input int len, input bit rnd);
    int total, beat, issued, popped, c, fv, fx, max_out;
    logic [9:0] ik, ek;
    logic [2:0] inn, en;
    logic el, held, exp_done;
    logic [45:0] hold_v, exp_v;
    total = len * N; beat = 0; issued = 0; popped = 0; c = 0; fv = -1; fx = -1; max_out = 0;
    ik = 10'(base); inn = '0; held = 0; hold_v = '0;
    checks++;
    if (cmd_ready !== 1'b1) begin errors++; $display("FAIL cmd_ready_at_start: got %b want 1", cmd_ready); end
    cmd_valid = 1; cmd_k_base = 10'(base); cmd_k_len = 11'(len);
    @(negedge clk);
    cmd_valid = 0;
    while (beat < total && c < 400) begin
      out_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      #1;
      if (x_en) begin
        checks++;
        if ({x_re, x_k, x_n} !== {1'b1, ik, inn}) begin
          errors++; $display("FAIL issue_addr: got re=%b k=%0d n=%0d want re=1 k=%0d n=%0d", x_re, x_k, x_n, ik, inn);
        end
        if (fx < 0) fx = c;
        issued++;
        inn++;
        if (inn == 3'(N - 1) + 3'd1) ik++;
      end
      if (issued - popped > max_out) max_out = issued - popped;
      exp_done = 1'b0;
      if (held) begin
        checks++;
        if ({out_valid, out_data, out_k, out_n, out_last} !== {1'b1, hold_v}) begin
          errors++; $display("FAIL stall_hold: got v=%b %h want v=1 %h", out_valid, {out_data, out_k, out_n, out_last}, hold_v);
        end
      end
      if (out_valid) begin
        if (fv < 0) fv = c;
        if (out_ready) begin
          ek = 10'(base + beat / N); en = 3'(beat % N); el = (beat == total - 1);
          exp_v = {word(ek, en), ek, en, el};
          checks++;
          if ({out_data, out_k, out_n, out_last} !== exp_v) begin
            errors++; $display("FAIL beat%0d: got %h want %h", beat, {out_data, out_k, out_n, out_last}, exp_v);
          end
          exp_done = el;
          beat++; popped++; held = 0;
        end else begin
          held = 1; hold_v = {out_data, out_k, out_n, out_last};
        end
      end else held = 0;
      checks++;
      if (done !== exp_done) begin errors++; $display("FAIL done_timing: cycle %0d got %b want %b", c, done, exp_done); end
      @(negedge clk);
      c++;
    end
    #1;
    checks++;
    if (beat != total) begin errors++; $display("FAIL timeout: got %0d beats want %0d", beat, total); end
    checks++;
    if (issued != total) begin errors++; $display("FAIL issue_count: got %0d want %0d", issued, total); end
    checks++;
    if (fx != 1 || fv != 3) begin errors++; $display("FAIL latency: got x_en@%0d valid@%0d want 1 and 3", fx, fv); end
    checks++;
    if (max_out > FD) begin errors++; $display("FAIL credit: got outstanding %0d want <= %0d", max_out, FD); end
    checks++;
    if ({busy, cmd_ready, done, out_valid} !== 4'b0100) begin
      errors++; $display("FAIL idle_after: got %b want 0100", {busy, cmd_ready, done, out_valid});
    end
  endtask

  task automatic test_reset;
    rst = 1; cmd_valid = 0; out_ready = 0; force_rv = 0;
    repeat (3) @(negedge clk);
    #1;
    checks++;
    if ({cmd_ready, busy, done, err_cmd, err_unexp, x_en, x_re, x_we, out_valid, out_last} !== 10'b1000000000) begin
      errors++; $display("FAIL reset_ctrl: got %b want 1000000000", {cmd_ready, busy, done, err_cmd, err_unexp, x_en, x_re, x_we, out_valid, out_last});
    end
    checks++;
    if ({x_k, x_n, out_k, out_n, out_data, x_wdata, x_wmask} !== '0) begin
      errors++; $display("FAIL reset_data: got %h want 0", {x_k, x_n, out_k, out_n, out_data, x_wdata, x_wmask});
    end
    @(negedge clk);
    rst = 0;
  endtask

  task automatic test_basic;
    run_cmd(2, 1, 0);
  endtask

  task automatic test_back_to_back;
    run_cmd(7, 1, 0);
    run_cmd(1020, 4, 0);
    run_cmd(3, 2, 0);
  endtask

  task automatic test_backpressure;
    run_cmd(0, 4, 1);
  endtask

  task automatic test_empty_range;
    int bases[2] = '{4, 1020};
    int lens[2] = '{0, 5};
    out_ready = 1;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      cmd_valid = 1; cmd_k_base = 10'(bases[i]); cmd_k_len = 11'(lens[i]);
      @(negedge clk);
      cmd_valid = 0;
      #1;
      checks++;
      if ({done, err_cmd, x_en, busy} !== {1'b1, 1'(i), 2'b00}) begin
        errors++; $display("FAIL empty_range%0d_pulse: got %b want %b", i, {done, err_cmd, x_en, busy}, {1'b1, 1'(i), 2'b00});
      end
      @(negedge clk);
      #1;
      checks++;
      if ({done, err_cmd, x_en, busy, out_valid} !== 5'b0) begin
        errors++; $display("FAIL empty_range%0d_after: got %b want 00000", i, {done, err_cmd, x_en, busy, out_valid});
      end
    end
  endtask

  task automatic test_unexpected;
    @(negedge clk);
    force_rv = 1;
    @(negedge clk);
    force_rv = 0;
    #1;
    checks++;
    if ({err_unexp, out_valid} !== 2'b10) begin errors++; $display("FAIL unexp_set: got %b want 10", {err_unexp, out_valid}); end
    repeat (2) @(negedge clk);
    #1;
    checks++;
    if ({err_unexp, out_valid} !== 2'b10) begin errors++; $display("FAIL unexp_sticky: got %b want 10", {err_unexp, out_valid}); end
    rst = 1;
    #1;
    checks++;
    if (err_unexp !== 1'b0) begin errors++; $display("FAIL unexp_clear: got %b want 0", err_unexp); end
    @(negedge clk);
    rst = 0;
  endtask

  task automatic test_reset_mid_drain;
    int beats, c;
    beats = 0; c = 0;
    out_ready = 1;
    cmd_valid = 1; cmd_k_base = 10'd0; cmd_k_len = 11'd2;
    @(negedge clk);
    cmd_valid = 0;
    while (beats < 10 && c < 200) begin
      #1;
      if (out_valid) beats++;
      @(negedge clk);
      c++;
    end
    checks++;
    if (beats != 10) begin errors++; $display("FAIL mid_timeout: got %0d beats want 10", beats); end
    rst = 1;
    #1;
    checks++;
    if ({cmd_ready, busy, done, err_cmd, err_unexp, x_en, x_re, out_valid, out_last} !== 9'b100000000) begin
      errors++; $display("FAIL mid_reset_ctrl: got %b want 100000000", {cmd_ready, busy, done, err_cmd, err_unexp, x_en, x_re, out_valid, out_last});
    end
    checks++;
    if ({x_k, x_n, out_k, out_n, out_data} !== '0) begin
      errors++; $display("FAIL mid_reset_data: got %h want 0", {x_k, x_n, out_k, out_n, out_data});
    end
    repeat (2) @(negedge clk);
    rst = 0;
    @(negedge clk);
    run_cmd(5, 1, 0);
  endtask

  initial begin
    test_reset();
    test_basic();
    test_back_to_back();
    test_backpressure();
    test_empty_range();
    test_unexpected();
    test_reset_mid_drain();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
